// File: rtl/mlx_i2c_pkg.sv
// Shared types and default widths for the MLX90640 I2C command path.
// Used by the requester arbiter and the I2C master wrapper.
package mlx_i2c_pkg;

    localparam int I2C_ADDR_W  = 16;
    localparam int I2C_DATA_W  = 16;
    localparam int I2C_MAX_REQ = 8;

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [I2C_ADDR_W-1:0] addr;
        logic [I2C_DATA_W-1:0] wdata;
    } i2c_cmd_t;

    function automatic logic [2:0] onehot_to_idx(input logic [I2C_MAX_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < I2C_MAX_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/mlx_i2c_arbiter_if.sv
// Requester-side and wrapper-side signals of the I2C arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface mlx_i2c_arbiter_if
    import mlx_i2c_pkg::*;
#(
    parameter int P_NUM_REQ = 2,
    parameter int P_ADDR_W  = I2C_ADDR_W,
    parameter int P_DATA_W  = I2C_DATA_W
);
    logic [P_NUM_REQ-1:0]          i_req_valid;
    logic [P_NUM_REQ-1:0]          o_req_ready;
    logic [P_NUM_REQ-1:0]          i_req_we;
    logic [P_NUM_REQ-1:0]          i_req_last;
    logic [P_NUM_REQ*P_ADDR_W-1:0] i_req_addr;
    logic [P_NUM_REQ*P_DATA_W-1:0] i_req_wdata;
    logic                          o_cmd_valid;
    logic                          i_cmd_ready;
    logic                          o_cmd_we;
    logic [P_ADDR_W-1:0]           o_cmd_addr;
    logic [P_DATA_W-1:0]           o_cmd_wdata;
    logic                          i_rsp_valid;
    logic [P_DATA_W-1:0]           i_rsp_data;
    logic [P_NUM_REQ-1:0]          o_rsp_valid;
    logic [P_DATA_W-1:0]           o_rsp_data;
    logic [P_NUM_REQ-1:0]          o_grant;
    logic                          o_err;

    modport slave (
        input  i_req_valid, i_req_we, i_req_last, i_req_addr, i_req_wdata,
        input  i_cmd_ready, i_rsp_valid, i_rsp_data,
        output o_req_ready, o_cmd_valid, o_cmd_we, o_cmd_addr, o_cmd_wdata,
        output o_rsp_valid, o_rsp_data, o_grant, o_err
    );

    modport master (
        output i_req_valid, i_req_we, i_req_last, i_req_addr, i_req_wdata,
        output i_cmd_ready, i_rsp_valid, i_rsp_data,
        input  o_req_ready, o_cmd_valid, o_cmd_we, o_cmd_addr, o_cmd_wdata,
        input  o_rsp_valid, o_rsp_data, o_grant, o_err
    );

endinterface

// File: rtl/mlx_rr_pick.sv
// Combinational round-robin picker: first valid requester above the last grant, with wrap.
module mlx_rr_pick #(
    parameter int P_NUM_REQ = 2,
    parameter int P_IDX_W   = 1
) (
    input  logic [P_NUM_REQ-1:0] i_valid,
    input  logic [P_IDX_W-1:0]   i_last_grant,
    output logic [P_NUM_REQ-1:0] o_grant
);
    always_comb begin
        logic found;
        int   k;
        o_grant = '0;
        found   = 1'b0;
        k       = 0;
        for (int off = 1; off <= P_NUM_REQ; off++) begin
            k = (int'(i_last_grant) + off) % P_NUM_REQ;
            if (!found && i_valid[k]) begin
                o_grant[k] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mu_fifo_sync.sv
// Single-clock show-ahead FIFO; push and pop in the same cycle are legal even when full.
module mu_fifo_sync #(
    parameter int P_WIDTH = 1,
    parameter int P_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic [P_WIDTH-1:0] i_data,
    input  logic               i_pop,
    output logic [P_WIDTH-1:0] o_data,
    output logic               o_full,
    output logic               o_empty
);
    localparam int AW = $clog2(P_DEPTH);

    logic [P_WIDTH-1:0] mem_q [P_DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               do_push, do_pop;

    // Extra pointer MSB tells full from empty when the slot indices match.
    always_comb begin
        o_empty  = (wr_ptr_q == rd_ptr_q);
        o_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = i_pop && !o_empty;
        do_push  = i_push && (!o_full || do_pop);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    assign o_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/mlx_i2c_arbiter.sv
// Round-robin, burst-locked arbiter in front of the MLX90640 I2C master wrapper.
// Optional lock watchdog is enabled by defining MLX_ARB_TIMEOUT_EN.
module mlx_i2c_arbiter
    import mlx_i2c_pkg::*;
#(
    parameter int P_NUM_REQ   = 2,
    parameter int P_ADDR_W    = I2C_ADDR_W,
    parameter int P_DATA_W    = I2C_DATA_W,
    parameter int P_RSP_DEPTH = 4,
    parameter int P_TIMEOUT   = 4096
) (
    input logic              i_clk,
    input logic              i_rst_n,
    mlx_i2c_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(P_NUM_REQ);

    arb_state_e           state_q, state_d;
    logic [P_NUM_REQ-1:0] grant_q, grant_d, pick;
    logic [ID_W-1:0]      gidx_q, gidx_d, last_q, last_d, fifo_dout;
    logic [2:0]           pick_idx;
    logic [P_NUM_REQ-1:0] rsp_valid_q, rsp_valid_d, req_ready;
    logic [P_DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic                 err_q, err_d;
    logic                 cmd_valid, rd_block, accept, tmo_hit;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;

    mlx_rr_pick #(.P_NUM_REQ(P_NUM_REQ), .P_IDX_W(ID_W)) u_pick (
        .i_valid      (bus.i_req_valid),
        .i_last_grant (last_q),
        .o_grant      (pick)
    );

    assign pick_idx = onehot_to_idx(I2C_MAX_REQ'(pick));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= ID_W'(P_NUM_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: if (|bus.i_req_valid) begin
                state_d = S_LOCK;
                grant_d = pick;
                gidx_d  = pick_idx[ID_W-1:0];
            end
            S_LOCK: if ((accept && bus.i_req_last[gidx_q]) || tmo_hit) begin
                state_d = S_IDLE;
                grant_d = '0;
                last_d  = gidx_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A read may only issue with a free ID slot; a same-cycle response pop frees one.
    always_comb begin
        rd_block  = ~bus.i_req_we[gidx_q] & fifo_full & ~bus.i_rsp_valid;
        cmd_valid = 1'b0;
        req_ready = '0;
        if (state_q == S_LOCK) begin
            cmd_valid         = bus.i_req_valid[gidx_q] & ~rd_block;
            req_ready[gidx_q] = bus.i_cmd_ready & ~rd_block;
        end
        accept    = cmd_valid & bus.i_cmd_ready;
        fifo_push = accept & ~bus.i_req_we[gidx_q];
        fifo_pop  = bus.i_rsp_valid & ~fifo_empty;
    end

    assign bus.o_cmd_valid = cmd_valid;
    assign bus.o_req_ready = req_ready;
    assign bus.o_grant     = grant_q;
    assign bus.o_cmd_we    = bus.i_req_we[gidx_q];
    assign bus.o_cmd_addr  = bus.i_req_addr[gidx_q*P_ADDR_W +: P_ADDR_W];
    assign bus.o_cmd_wdata = bus.i_req_wdata[gidx_q*P_DATA_W +: P_DATA_W];

    mu_fifo_sync #(.P_WIDTH(ID_W), .P_DEPTH(P_RSP_DEPTH)) u_id_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_data  (gidx_q),
        .i_pop   (fifo_pop),
        .o_data  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (fifo_pop) begin
            rsp_valid_d[fifo_dout] = 1'b1;
            rsp_data_d             = bus.i_rsp_data;
        end
        err_d = (bus.i_rsp_valid & fifo_empty) | tmo_hit;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_data  = rsp_data_q;
    assign bus.o_err       = err_q;

`ifdef MLX_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(P_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Counts idle cycles of the owner; the outstanding-read FIFO survives a forced release.
    always_comb begin
        tmo_cnt_d = '0;
        tmo_hit   = 1'b0;
        if (state_q == S_LOCK && !accept) begin
            if (!bus.i_req_valid[gidx_q]) begin
                if (tmo_cnt_q == TMO_W'(P_TIMEOUT - 1)) tmo_hit = 1'b1;
                else tmo_cnt_d = tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) tmo_cnt_q <= '0;
        else          tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: doc/mlx_i2c_arbiter.md
# mlx_i2c_arbiter

Shares the single 16-bit-register I2C master wrapper between several command requesters, for example the MLX90640 frame readout controller and the EEPROM/configuration loader. Arbitration is round-robin. A grant is locked for a multi-command burst. Read responses are routed back to the requester that issued them. The block sits directly in front of the I2C master wrapper's command/response interface inside the MLX90640 top.

## Interface
Parameters:
- P_NUM_REQ, 2 — number of requesters (2..8)
- P_ADDR_W, 16 — register address width
- P_DATA_W, 16 — register data width
- P_RSP_DEPTH, 4 — outstanding-read ID FIFO depth (power of 2)
- P_TIMEOUT, 4096 — lock watchdog limit in cycles (used only with MLX_ARB_TIMEOUT_EN)

Ports:
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  reset, synchronous, active-low
- i_req_valid  in  P_NUM_REQ  per-requester command valid
- o_req_ready  out  P_NUM_REQ  per-requester command accepted
- i_req_we  in  P_NUM_REQ  1 = write, 0 = read
- i_req_last  in  P_NUM_REQ  last command of burst; releases the lock
- i_req_addr  in  P_NUM_REQ*P_ADDR_W  flattened; requester k at [k*P_ADDR_W +: P_ADDR_W]
- i_req_wdata  in  P_NUM_REQ*P_DATA_W  flattened write data
- o_cmd_valid  out  1  command to the I2C wrapper
- i_cmd_ready  in  1  wrapper accepts the command
- o_cmd_we, o_cmd_addr, o_cmd_wdata  out  1/P_ADDR_W/P_DATA_W  muxed command fields
- i_rsp_valid  in  1  read data valid from the wrapper (one per read)
- i_rsp_data  in  P_DATA_W  read data
- o_rsp_valid  out  P_NUM_REQ  one-hot response strobe to the owning requester
- o_rsp_data  out  P_DATA_W  registered read data, common to all requesters
- o_grant  out  P_NUM_REQ  one-hot current owner; 0 when idle
- o_err  out  1  one-cycle pulse on a protocol error

## Operation
- States: S_IDLE, S_LOCK.
- S_IDLE with any i_req_valid: pick the first requester with valid set, searching upward from (last_grant+1) mod P_NUM_REQ with wrap. Register the choice in o_grant and go to S_LOCK. last_grant resets to P_NUM_REQ-1, so requester 0 wins the first tie.
- In S_LOCK the datapath is combinational:
  - o_cmd_valid = i_req_valid[g] & ~rd_block.
  - o_req_ready[g] = i_cmd_ready & ~rd_block; every other requester's ready is 0.
  - o_cmd_* fields are the granted requester's fields.
- rd_block = ~i_req_we[g] & id_fifo_full & ~i_rsp_valid. A read cannot be issued without a free ID slot. A same-cycle pop frees a slot.
- Beat accepted = o_cmd_valid & i_cmd_ready.
  - An accepted read pushes g into the ID FIFO.
  - An accepted beat with i_req_last[g] = 1 updates last_grant = g, clears o_grant and returns to S_IDLE.
- A requester that drops valid mid-burst keeps the lock; the bus stays idle.
- i_rsp_valid with a non-empty FIFO: pop the id. On the next cycle, o_rsp_valid[id] = 1 and o_rsp_data = i_rsp_data.
- i_rsp_valid with an empty FIFO: response dropped, o_err pulses, no o_rsp_valid.
- Simultaneous push and pop is legal at any occupancy, including full; the count is unchanged.
- Responses return in issue order; the wrapper is strictly in-order.

## Timing
- Reset values: o_grant = 0, o_cmd_valid = 0, o_req_ready = 0, o_rsp_valid = 0, o_rsp_data = 0, o_err = 0. The state is S_IDLE and the ID FIFO is empty.
- Reset asserted mid-burst or with outstanding reads: all of the above takes effect on the next edge; pending responses are discarded.
- Grant latency: a request seen in S_IDLE at edge n gives o_grant and o_cmd_valid from cycle n+1.
- Burst release: the last beat is accepted at edge n, S_IDLE holds for cycle n+1, and a new grant appears at n+2. There is a fixed one-cycle arbitration bubble and no same-cycle re-grant.
- Sustained throughput inside a burst: 1 command/cycle, limited only by i_cmd_ready.
- Response latency: i_rsp_valid to o_rsp_valid is exactly 1 cycle, registered.

## Configuration
- MLX_ARB_TIMEOUT_EN defined:
  - A counter runs in S_LOCK while i_req_valid[g] = 0 and resets on any beat.
  - When it reaches P_TIMEOUT, o_err pulses, the lock is force-released (last_grant = g, S_IDLE) and the ID FIFO is kept.
- MLX_ARB_TIMEOUT_EN undefined: no counter; the lock is held indefinitely until i_req_last is accepted.

## Structure
- Package mlx_i2c_pkg: state enum (S_IDLE, S_LOCK), cmd struct {we, addr, wdata}, default width constants shared with the I2C wrapper.
- Sub-module mlx_rr_pick: combinational round-robin picker (valid vector plus last_grant in, one-hot grant out).
- The ID FIFO is an instance of mu_fifo_sync with width $clog2(P_NUM_REQ) and depth P_RSP_DEPTH.

## Test plan
- Single requester 0: 3-write burst (last on the third) with i_cmd_ready = 1 -> o_grant = 01 from cycle 1, three beats on consecutive cycles, grant 00 after the third.
- Both requesters valid from reset -> requester 0 granted first; after its last beat, one idle cycle, then requester 1 granted; repeated traffic strictly alternates.
- Requester 1 issues 4 reads with P_RSP_DEPTH = 4 and no responses -> 4 accepted, fifth held (o_req_ready = 0). Then i_rsp_valid with data 0x1234 -> o_rsp_valid = 10 and o_rsp_data = 0x1234 one cycle later; fifth read accepted in the same cycle as the pop.
- Interleaved reads: requester 0 reads 0x2400, then requester 1 reads 0x800D; responses 0xAAAA, 0xBBBB -> 0xAAAA goes to requester 0 and 0xBBBB to requester 1.
- i_rsp_valid with the FIFO empty -> o_err pulses for 1 cycle, o_rsp_valid stays 0.
- With MLX_ARB_TIMEOUT_EN and P_TIMEOUT = 16: requester 0 drops valid mid-burst -> after 16 cycles o_err pulses and o_grant goes to 0. Separately, reset mid-burst -> all outputs return to 0 and the FIFO is empty.
